// File: rtl/frontend_pkg.sv
// Shared front-end types and constants for the F0 fetch-address generator
// and the F1-side consumers/checkers of the even/odd cache-line pair.
package frontend_pkg;

  localparam int unsigned XLEN_DFLT      = 32;
  localparam int unsigned CLC_WIDTH_DFLT = 28;
  // Byte-offset bits below the cache-line address (16 B lines by default).
  localparam int unsigned LINE_OFF       = XLEN_DFLT - CLC_WIDTH_DFLT;
  localparam int unsigned EPOCH_W_DFLT   = 2;
  localparam logic [XLEN_DFLT-1:0] RESET_PC_DFLT = 32'h0000_1000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_REDIRECT
  } f0_state_e;

  // Even/odd candidate pair as seen by F1.
  typedef struct packed {
    logic [CLC_WIDTH_DFLT-1:0] even;
    logic [CLC_WIDTH_DFLT-1:0] odd;
    logic                      first_is_odd;
  } clc_pair_t;

endpackage

// File: rtl/f0_clc_gen_if.sv
// F0 <-> F1 fetch interface.
//   master : F0 side (receives stall/redirect, drives the CLC pair)
//   slave  : F1 side (drives stall/redirect, receives the CLC pair)
interface f0_clc_gen_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CLC_WIDTH = 28,
  parameter int unsigned EPOCH_W   = 2
);

  logic                 stall_in;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic [CLC_WIDTH-1:0] clc_even_out;
  logic [CLC_WIDTH-1:0] clc_odd_out;
  logic                 clc_valid;
  logic                 first_is_odd;
  logic [XLEN-1:0]      fetch_pc_out;
  logic [EPOCH_W-1:0]   epoch_out;

  modport master (
    input  stall_in, redirect_valid, redirect_pc,
    output clc_even_out, clc_odd_out, clc_valid, first_is_odd,
           fetch_pc_out, epoch_out
  );

  modport slave (
    output stall_in, redirect_valid, redirect_pc,
    input  clc_even_out, clc_odd_out, clc_valid, first_is_odd,
           fetch_pc_out, epoch_out
  );

endinterface

// File: rtl/clc_pair_calc.sv
// Combinational even/odd cache-line pair calculator.
//   pc_i             : fetch PC
//   even_c_o         : even-bank line address (bit0 = 0)
//   odd_c_o          : odd-bank line address (bit0 = 1)
//   first_is_odd_c_o : line holding pc_i is the odd one
//   next_pc_c_o      : start of the following line (wraps at 2^XLEN)
module clc_pair_calc #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CLC_WIDTH = 28
) (
  input  logic [XLEN-1:0]      pc_i,
  output logic [CLC_WIDTH-1:0] even_c_o,
  output logic [CLC_WIDTH-1:0] odd_c_o,
  output logic                 first_is_odd_c_o,
  output logic [XLEN-1:0]      next_pc_c_o
);

  localparam int unsigned OFF = XLEN - CLC_WIDTH;

  logic [CLC_WIDTH-1:0] line;
  logic [CLC_WIDTH-1:0] line_inc;
  logic                 unused_low;

  assign line     = pc_i[XLEN-1:OFF];
  assign line_inc = line + CLC_WIDTH'(1);
  // Byte offset only matters for the fetch_pc itself, not the line pair.
  assign unused_low = ^pc_i[OFF-1:0];

  assign first_is_odd_c_o = line[0];
  assign even_c_o         = line[0] ? line_inc : line;
  assign odd_c_o          = line[0] ? line : {line[CLC_WIDTH-1:1], 1'b1};
  // Sequential advance realigns to the next line boundary.
  assign next_pc_c_o      = {line_inc, {OFF{1'b0}}};

endmodule

// File: rtl/f0_clc_gen.sv
// F0 fetch-address generator: owns the fetch PC and registers the even/odd
// cache-line pair for F1 each cycle, with stall hold and epoch-tagged
// redirects.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : F0 side of f0_clc_gen_if (stall/redirect in, registered pair out)
module f0_clc_gen
  import frontend_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DFLT,
  parameter int unsigned     CLC_WIDTH = CLC_WIDTH_DFLT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DFLT),
  parameter int unsigned     EPOCH_W   = EPOCH_W_DFLT
) (
  input  logic         clk,
  input  logic         rst,
  f0_clc_gen_if.master bus
);

  f0_state_e            state_q;
  logic [XLEN-1:0]      pc_q;
  logic [XLEN-1:0]      fetch_pc_q;
  logic [CLC_WIDTH-1:0] even_q;
  logic [CLC_WIDTH-1:0] odd_q;
  logic                 first_is_odd_q;
  logic                 valid_q;
  logic [EPOCH_W-1:0]   epoch_q;

  logic [XLEN-1:0]      src_pc;
  logic [XLEN-1:0]      next_pc_d;
  logic [CLC_WIDTH-1:0] even_d;
  logic [CLC_WIDTH-1:0] odd_d;
  logic                 first_is_odd_d;
  logic                 load_c;

  // A redirect always wins the pair source; otherwise use the running PC
  // (which holds RESET_PC while in BOOT).
  assign src_pc = bus.redirect_valid ? bus.redirect_pc : pc_q;

  clc_pair_calc #(
    .XLEN      (XLEN),
    .CLC_WIDTH (CLC_WIDTH)
  ) u_pair (
    .pc_i             (src_pc),
    .even_c_o         (even_d),
    .odd_c_o          (odd_d),
    .first_is_odd_c_o (first_is_odd_d),
    .next_pc_c_o      (next_pc_d)
  );

  // Output load enable: redirects always load, BOOT loads regardless of
  // stall, RUN/REDIRECT load when not stalled, HOLD never loads (including
  // its exit edge).
  always_comb begin
    load_c = 1'b0;
    if (bus.redirect_valid) begin
      load_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_BOOT:     load_c = 1'b1;
        ST_RUN:      load_c = !bus.stall_in;
        ST_REDIRECT: load_c = !bus.stall_in;
        ST_HOLD:     load_c = 1'b0;
      endcase
    end
  end

  // State, PC and registered pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      fetch_pc_q     <= '0;
      even_q         <= '0;
      odd_q          <= '0;
      first_is_odd_q <= 1'b0;
      valid_q        <= 1'b0;
      epoch_q        <= '0;
    end else begin
      if (load_c) begin
        pc_q           <= next_pc_d;
        fetch_pc_q     <= src_pc;
        even_q         <= even_d;
        odd_q          <= odd_d;
        first_is_odd_q <= first_is_odd_d;
        valid_q        <= 1'b1;
      end
      if (bus.redirect_valid) begin
        epoch_q <= epoch_q + EPOCH_W'(1);
        state_q <= ST_REDIRECT;
      end else begin
        unique case (state_q)
          ST_BOOT:     state_q <= ST_RUN;
          ST_RUN:      state_q <= bus.stall_in ? ST_HOLD : ST_RUN;
          ST_REDIRECT: state_q <= bus.stall_in ? ST_HOLD : ST_RUN;
          ST_HOLD:     state_q <= bus.stall_in ? ST_HOLD : ST_RUN;
        endcase
      end
    end
  end

  assign bus.clc_even_out = even_q;
  assign bus.clc_odd_out  = odd_q;
  assign bus.clc_valid    = valid_q;
  assign bus.first_is_odd = first_is_odd_q;
  assign bus.fetch_pc_out = fetch_pc_q;
  assign bus.epoch_out    = epoch_q;

endmodule

// File: tb/tb_f0_clc_gen.sv
// Self-checking bench for f0_clc_gen: directed scenarios plus randomized
// stall/redirect traffic against a line-arithmetic reference model.
module tb_f0_clc_gen;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 28;
  localparam int unsigned EW   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic clk;
  logic rst_n;

  f0_clc_gen_if #(.XLEN(XLEN), .CLC_WIDTH(CW), .EPOCH_W(EW)) f0_bus ();

  f0_clc_gen #(
    .XLEN      (XLEN),
    .CLC_WIDTH (CW),
    .RESET_PC  (RST_PC),
    .EPOCH_W   (EW)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (f0_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch proceeds line by line; a pair is the line holding
  // the address plus its bank partner.
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  logic [27:0] m_even;
  logic [27:0] m_odd;
  logic        m_fio;
  logic        m_valid;
  logic [1:0]  m_epoch;
  bit          m_boot;
  bit          m_hold;

  task automatic m_reset();
    m_pc = RST_PC; m_fpc = '0; m_even = '0; m_odd = '0;
    m_fio = 1'b0; m_valid = 1'b0; m_epoch = '0; m_boot = 1'b1; m_hold = 1'b0;
  endtask

  task automatic m_load(input logic [31:0] a);
    logic [31:0] l;
    l = a / 16;
    if (l % 2 == 0) begin
      m_even = 28'(l);
      m_odd  = 28'(l + 32'd1);
      m_fio  = 1'b0;
    end else begin
      m_odd  = 28'(l);
      m_even = 28'(l + 32'd1);
      m_fio  = 1'b1;
    end
    m_pc    = 32'((64'(l) + 64'd1) * 64'd16);
    m_fpc   = a;
    m_valid = 1'b1;
  endtask

  task automatic m_edge(input bit st, input bit rv, input logic [31:0] rpc);
    if (rv) begin
      m_load(rpc);
      m_epoch = m_epoch + 2'd1;
      m_boot = 1'b0;
      m_hold = 1'b0;
    end else if (m_boot) begin
      m_load(m_pc);
      m_boot = 1'b0;
    end else if (m_hold) begin
      if (!st) m_hold = 1'b0;
    end else if (st) begin
      m_hold = 1'b1;
    end else begin
      m_load(m_pc);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(f0_bus.clc_valid),    32'(m_valid));
    check({tag, ".even"},  32'(f0_bus.clc_even_out), 32'(m_even));
    check({tag, ".odd"},   32'(f0_bus.clc_odd_out),  32'(m_odd));
    check({tag, ".fio"},   32'(f0_bus.first_is_odd), 32'(m_fio));
    check({tag, ".pc"},    f0_bus.fetch_pc_out,      m_fpc);
    check({tag, ".epoch"}, 32'(f0_bus.epoch_out),    32'(m_epoch));
  endtask

  task automatic step(input string tag, input bit st, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    f0_bus.stall_in       = st;
    f0_bus.redirect_valid = rv;
    f0_bus.redirect_pc    = rpc;
    @(posedge clk);
    m_edge(st, rv, rpc);
    #1;
    compare_all(tag);
  endtask

  // Reset asserted between edges, released just after a later edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    compare_all(tag);
    check({tag, ".valid0"}, 32'(f0_bus.clc_valid), 32'd0);
    check({tag, ".epoch0"}, 32'(f0_bus.epoch_out), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit          st;
    bit          rv;
    logic [31:0] rpc;

    rst_n = 1'b0;
    f0_bus.stall_in = 1'b0;
    f0_bus.redirect_valid = 1'b0;
    f0_bus.redirect_pc = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 compare_all("reset");
    #1 rst_n = 1'b1;

    // Boot and sequential advance
    step("boot", 1'b0, 1'b0, '0);
    check("boot.pc_k",   f0_bus.fetch_pc_out,        32'h0000_1000);
    check("boot.even_k", 32'(f0_bus.clc_even_out),   32'h0000100);
    check("boot.odd_k",  32'(f0_bus.clc_odd_out),    32'h0000101);
    step("seq", 1'b0, 1'b0, '0);
    check("seq.pc_k",   f0_bus.fetch_pc_out,       32'h0000_1010);
    check("seq.even_k", 32'(f0_bus.clc_even_out),  32'h0000102);
    check("seq.fio_k",  32'(f0_bus.first_is_odd),  32'd1);

    // Stall hold and release
    repeat (3) begin
      step("stall", 1'b1, 1'b0, '0);
      check("stall.pc_k", f0_bus.fetch_pc_out, 32'h0000_1010);
    end
    step("unstall", 1'b0, 1'b0, '0);
    check("unstall.pc_k", f0_bus.fetch_pc_out, 32'h0000_1010);
    step("resume", 1'b0, 1'b0, '0);
    check("resume.pc_k",  f0_bus.fetch_pc_out,      32'h0000_1020);
    check("resume.odd_k", 32'(f0_bus.clc_odd_out),  32'h0000103);

    // Redirect during stall
    step("pre_rd", 1'b1, 1'b0, '0);
    step("rd_stall", 1'b1, 1'b1, 32'h0000_2008);
    check("rd_stall.pc_k",    f0_bus.fetch_pc_out,     32'h0000_2008);
    check("rd_stall.even_k",  32'(f0_bus.clc_even_out), 32'h0000200);
    check("rd_stall.epoch_k", 32'(f0_bus.epoch_out),    32'd1);
    step("post_rd", 1'b0, 1'b0, '0);
    check("post_rd.pc_k", f0_bus.fetch_pc_out, 32'h0000_2010);

    // Address-space wrap
    step("wrap", 1'b0, 1'b1, 32'hFFFF_FFF4);
    check("wrap.odd_k",  32'(f0_bus.clc_odd_out),  32'h0FFFFFFF);
    check("wrap.even_k", 32'(f0_bus.clc_even_out), 32'h0000000);
    step("wrap_nxt", 1'b0, 1'b0, '0);
    check("wrap_nxt.pc_k",  f0_bus.fetch_pc_out,     32'h0000_0000);
    check("wrap_nxt.odd_k", 32'(f0_bus.clc_odd_out), 32'h0000001);

    // Async reset mid-run, then back-to-back redirects starting in BOOT
    async_reset("arst");
    step("rd1", 1'b0, 1'b1, 32'h0000_3000);
    check("rd1.epoch_k", 32'(f0_bus.epoch_out), 32'd1);
    step("rd2", 1'b0, 1'b1, 32'h0000_4004);
    check("rd2.epoch_k", 32'(f0_bus.epoch_out), 32'd2);
    step("rd3", 1'b1, 1'b1, 32'h0000_5018);
    check("rd3.epoch_k", 32'(f0_bus.epoch_out), 32'd3);
    step("rd4", 1'b0, 1'b1, 32'h0000_6000);
    check("rd4.epoch_k", 32'(f0_bus.epoch_out), 32'd0);
    step("rd_seq", 1'b0, 1'b0, '0);
    check("rd_seq.pc_k", f0_bus.fetch_pc_out, 32'h0000_6010);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("rnd_arst");
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 12);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFC0 | ($urandom & 32'h3F);
      step("rnd", st, rv, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/f0_clc_gen.md
Name: f0_clc_gen

Overview:
Front-end fetch-address generator (F0). Owns the fetch PC and, each cycle, produces the even/odd cache-line candidate pair that feeds the F1 translation stage's clc_even_in/clc_odd_in. Provides sequential next-line advance, redirect handling with an epoch tag, and stall hold. It is the producing end of the F1 CLC interface.

Parameters:
XLEN, 32, PC/address width.
CLC_WIDTH, 28, cache-line address width; OFF = XLEN-CLC_WIDTH (default 4, i.e. 16 B lines).
RESET_PC, 32'h0000_1000, PC loaded on reset.
EPOCH_W, 2, width of the redirect epoch counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_in  in  1  F1 back-pressure; hold all outputs and PC
redirect_valid  in  1  branch/exception resteer request
redirect_pc  in  XLEN  resteer target
clc_even_out  out  CLC_WIDTH  even-bank line address (bit0 = 0), drives F1 clc_even_in
clc_odd_out  out  CLC_WIDTH  odd-bank line address (bit0 = 1), drives F1 clc_odd_in
clc_valid  out  1  pair valid
first_is_odd  out  1  1 = the line containing fetch_pc is the odd line
fetch_pc_out  out  XLEN  PC the pair was generated for
epoch_out  out  EPOCH_W  epoch of the current pair

Behaviour:
- Reset (rst low, asynchronous): state=BOOT, pc=RESET_PC, clc_valid=0, clc_even_out=0, clc_odd_out=0, first_is_odd=0, fetch_pc_out=0, epoch_out=0.
- All outputs registered; 1-cycle latency from pc/redirect to outputs.
- Pair calc (combinational, from an XLEN pc): L = pc[XLEN-1:OFF]. If L[0]=0: even=L, odd=L+1 (that is, L|1), first_is_odd=0. If L[0]=1: odd=L, even=L+1 modulo 2^CLC_WIDTH, first_is_odd=1.
- Next sequential pc = {L+1, OFF'b0} modulo 2^XLEN. A misaligned pc is realigned after the first advance.
- States:
  BOOT: on the first posedge after rst deasserts, load outputs from RESET_PC, clc_valid=1, go to RUN, pc <= next(RESET_PC). BOOT ignores stall_in.
  RUN: if redirect_valid, go to REDIRECT. Else if stall_in, go to HOLD. Else load outputs from pc and advance pc.
  HOLD: all outputs and pc frozen. When stall_in=0, go to RUN; no output update happens on the exit edge. If redirect_valid, go to REDIRECT.
  REDIRECT (taken on the same edge redirect_valid is sampled, from RUN or HOLD): outputs load from redirect_pc, clc_valid=1, epoch increments (wraps modulo 2^EPOCH_W), pc <= next(redirect_pc), return to RUN.
- Redirect priority: redirect_valid has priority over stall_in. A redirect asserted during stall still updates outputs and epoch on that edge. F1 must treat the new pair as replacing the stalled one.
- Back-to-back redirects: each one loads and increments the epoch; the last one wins.
- Redirect in BOOT: redirect is honoured, output is the redirect pair, epoch=1.
- Reset mid-operation: immediate return to the reset values, with clc_valid low asynchronously.
- clc_valid stays 1 from BOOT exit onward; it only drops in reset. Invalidation of in-flight pairs downstream uses epoch_out.

Decomposition:
- frontend_pkg:
  - OFF constant (XLEN-CLC_WIDTH).
  - f0 state enum {BOOT, RUN, HOLD, REDIRECT}.
  - default RESET_PC.
  - EPOCH_W.
  - A typedef for the clc pair struct {even, odd, first_is_odd}.
- One natural sub-module: clc_pair_calc (combinational pc -> even/odd/first_is_odd/next_pc). It is reused by F1/BTB-side checkers.

Test Plan:
1. Reset release, RESET_PC=0x1000, no stall. Cycle 1: even=0x0000100, odd=0x0000101, first_is_odd=0, fetch_pc=0x1000, valid=1. Cycle 2: fetch_pc=0x1010, odd=0x0000101, even=0x0000102, first_is_odd=1.
2. stall_in high for 3 cycles after cycle 2. Outputs hold fetch_pc=0x1010 for all 3 cycles. After release, the next update is fetch_pc=0x1020 (even=0x102, odd=0x103).
3. redirect_valid with redirect_pc=0x0000_2008 while stall_in=1. Next edge: fetch_pc=0x2008, even=0x200, odd=0x201, epoch 0->1. The following sequential pc is 0x2010.
4. Wrap case: redirect_pc=0xFFFF_FFF4 gives odd=0xFFFFFFF, even=0x0000000, first_is_odd=1. The next pc is 0x0000_0000 (even=0x000, odd=0x001).
5. Four consecutive redirects: epoch goes 1, 2, 3, 0. The outputs track each target on its own edge.
6. Assert rst low asynchronously mid-RUN (between edges): clc_valid=0 and epoch=0 immediately. Release restarts at BOOT with the RESET_PC pair.
